// File: rtl/led_matrix_scanner.sv
// Multiplexed LED matrix scanner: double-buffered frame store, per-row BLANK/ON
// phases with 8-bit PWM brightness, and tear-free buffer swaps at frame boundaries.
module led_matrix_scanner #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int PRESCALE       = 1,
  parameter int BLANK_TICKS    = 2,
  parameter bit COL_ACTIVE_LOW = 1'b1,
  localparam int RW            = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_addr,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
  input  logic [7:0]      brightness,
  output logic [ROWS-1:0] led_row,
  output logic [COLS-1:0] led_col,
  output logic [RW-1:0]   row_addr,
  output logic            frame_start,
  output logic            swap_done,
  output logic            dbg_state   // 0 = BLANK, 1 = ON
);

  typedef enum logic {ST_BLANK = 1'b0, ST_ON = 1'b1} state_e;

  localparam logic [COLS-1:0] COL_OFF = COL_ACTIVE_LOW ? '1 : '0;

  // Handshakes: wr_en and swap_req are single-cycle strobes sampled on every
  // rising edge while reset is low; there is no back-pressure (always ready).

  state_e          state, state_nxt;
  logic            started;
  logic [15:0]     tick_cnt;
  logic            tick;
  logic [7:0]      blank_cnt, blank_nxt;
  logic [7:0]      on_cnt, on_nxt;
  logic [7:0]      bright_lat, bright_nxt;
  logic [RW-1:0]   row_nxt;
  logic            wrap;
  logic            frame_edge;
  logic            swap_now;
  logic            front_sel;
  logic            swap_pending;
  logic            wr_ok;
  logic            lit_nxt;
  logic [COLS-1:0] front_row;
  logic [COLS-1:0] bank0 [ROWS];
  logic [COLS-1:0] bank1 [ROWS];

  // The first edge after reset only arms the scan, so it counts as the
  // row 0 BLANK entry and the frame period stays exact from then on.
  assign tick       = started && (tick_cnt == 16'(PRESCALE - 1));
  assign wr_ok      = wr_en && (int'(wr_addr) < ROWS);
  assign frame_edge = !started || wrap;
  assign swap_now   = frame_edge && swap_pending;
  assign front_row  = front_sel ? bank1[row_nxt] : bank0[row_nxt];
  assign lit_nxt    = (state_nxt == ST_ON) && (on_nxt < bright_nxt);
  assign dbg_state  = state;

  always_comb begin
    state_nxt  = state;
    blank_nxt  = blank_cnt;
    on_nxt     = on_cnt;
    bright_nxt = bright_lat;
    row_nxt    = row_addr;
    wrap       = 1'b0;
    if (tick) begin
      case (state)
        ST_BLANK: begin
          if (blank_cnt == 8'(BLANK_TICKS - 1)) begin
            state_nxt  = ST_ON;
            blank_nxt  = '0;
            on_nxt     = '0;
            bright_nxt = brightness;
          end else begin
            blank_nxt = blank_cnt + 8'd1;
          end
        end
        ST_ON: begin
          if (on_cnt == 8'hFF) begin
            state_nxt = ST_BLANK;
            on_nxt    = '0;
            if (row_addr == RW'(ROWS - 1)) begin
              row_nxt = '0;
              wrap    = 1'b1;
            end else begin
              row_nxt = row_addr + RW'(1);
            end
          end else begin
            on_nxt = on_cnt + 8'd1;
          end
        end
        default: state_nxt = ST_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_BLANK;
      started      <= 1'b0;
      tick_cnt     <= '0;
      blank_cnt    <= '0;
      on_cnt       <= '0;
      bright_lat   <= '0;
      row_addr     <= '0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      led_row      <= '0;
      led_col      <= COL_OFF;
      frame_start  <= 1'b0;
      swap_done    <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        bank0[r] <= '0;
        bank1[r] <= '0;
      end
    end else begin
      started <= 1'b1;
      if (started) tick_cnt <= tick ? '0 : tick_cnt + 16'd1;
      state       <= state_nxt;
      blank_cnt   <= blank_nxt;
      on_cnt      <= on_nxt;
      bright_lat  <= bright_nxt;
      row_addr    <= row_nxt;
      frame_start <= frame_edge;
      swap_done   <= swap_now;
      // A request landing on the swap edge itself is kept for the next frame.
      if (swap_now) begin
        front_sel    <= !front_sel;
        swap_pending <= swap_req;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
      // Writes target the pre-swap back bank, even on the swap edge.
      if (wr_ok) begin
        if (front_sel) bank0[wr_addr] <= wr_data;
        else           bank1[wr_addr] <= wr_data;
      end
      led_row <= (state_nxt == ST_ON) ? (ROWS'(1) << row_nxt) : '0;
      led_col <= lit_nxt ? (COL_ACTIVE_LOW ? ~front_row : front_row) : COL_OFF;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: frame-position reference model checked every cycle,
// a table of write/brightness vectors, and hand sequences for swap and reset corners.
module tb_led_matrix_scanner;

  localparam int ROWS  = 8;
  localparam int BL    = 2;
  localparam int ROW_T = BL + 256;
  localparam int FRAME = ROWS * ROW_T;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       swap_req = 1'b0;
  logic [7:0] brightness = '0;

  logic [7:0] led_row, led_col;
  logic [2:0] row_addr;
  logic       frame_start, swap_done, dbg_state;

  logic [5:0] led_row6;
  logic [7:0] led_col6;
  logic [2:0] row_addr6;
  logic       frame_start6, swap_done6, dbg_state6;

  led_matrix_scanner dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .brightness(brightness), .led_row(led_row), .led_col(led_col),
    .row_addr(row_addr), .frame_start(frame_start), .swap_done(swap_done),
    .dbg_state(dbg_state)
  );

  // Six-row instance: addresses 6 and 7 are out of range there.
  led_matrix_scanner #(.ROWS(6)) dut6 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .brightness(brightness), .led_row(led_row6), .led_col(led_col6),
    .row_addr(row_addr6), .frame_start(frame_start6), .swap_done(swap_done6),
    .dbg_state(dbg_state6)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: everything derives from the cycle count since the frame
  // started, split arithmetically into row and phase position.
  logic [7:0] m_bank [2][ROWS];
  int         m_front, m_back, m_t, m_p, m_rowi, m_r, m_bright;
  bit         m_started, m_pend, m_bnd, chk_en = 1'b0;
  logic [7:0] e_row, e_col;
  logic [2:0] e_addr;
  logic       e_fs, e_sd, e_on;

  always @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++) m_bank[b][r] = 8'h00;
      m_front = 0; m_pend = 0; m_bright = 0; m_started = 0;
      e_row = 8'h00; e_col = 8'hFF; e_addr = 3'd0; e_fs = 0; e_sd = 0; e_on = 0;
    end else begin
      if (!m_started) begin
        m_started = 1; m_t = 0; m_bnd = 1;
      end else begin
        m_t++;
        m_bnd = (m_t % FRAME) == 0;
      end
      m_p = m_t % FRAME;
      m_rowi = m_p / ROW_T;
      m_r = m_p % ROW_T;
      if (m_r == BL) m_bright = int'(brightness);
      m_back = 1 - m_front;
      if (wr_en && int'(wr_addr) < ROWS) m_bank[m_back][wr_addr] = wr_data;
      e_sd = 0;
      if (m_bnd && m_pend) begin
        m_front = m_back; e_sd = 1; m_pend = swap_req;
      end else if (swap_req) begin
        m_pend = 1;
      end
      e_fs = m_bnd;
      e_addr = 3'(m_rowi);
      e_on = (m_r >= BL);
      e_row = e_on ? 8'(1 << m_rowi) : 8'h00;
      e_col = (e_on && (m_r - BL) < m_bright) ? ~m_bank[m_front][m_rowi] : 8'hFF;
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle", {led_row, led_col, row_addr, frame_start, swap_done, dbg_state},
                     {e_row, e_col, e_addr, e_fs, e_sd, e_on});
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_row(input int r, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = 3'(r); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  task automatic wait_fs(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 5000);
    check(nm, frame_start, 1);
  endtask

  task automatic wait_sd(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!swap_done && n < 5000);
    check(nm, swap_done, 1);
  endtask

  typedef struct {
    int         row;
    logic [7:0] data;
    logic [7:0] bright;
    int         exp_on;
    int         exp_lit;
    logic [7:0] exp_col;
    bit         chk_dark;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lit, on, other, flit;
    vecs[0] = '{row: 3, data: 8'hA5, bright: 8'd255, exp_on: 256, exp_lit: 255, exp_col: 8'h5A, chk_dark: 0};
    vecs[1] = '{row: 0, data: 8'hFF, bright: 8'd64,  exp_on: 256, exp_lit: 64,  exp_col: 8'h00, chk_dark: 0};
    vecs[2] = '{row: 6, data: 8'h3C, bright: 8'd0,   exp_on: 256, exp_lit: 0,   exp_col: 8'hC3, chk_dark: 1};
    vecs[3] = '{row: 7, data: 8'h81, bright: 8'd1,   exp_on: 256, exp_lit: 1,   exp_col: 8'h7E, chk_dark: 0};
    vecs[4] = '{row: 1, data: 8'h5A, bright: 8'd128, exp_on: 256, exp_lit: 128, exp_col: 8'hA5, chk_dark: 0};

    // Reset state, then the first frame with empty banks.
    brightness = 8'd255;
    reset = 1'b1;
    tick_n(3);
    check("rst_led_row", led_row, 8'h00);
    check("rst_led_col", led_col, 8'hFF);
    check("rst_frame_start", frame_start, 0);
    check("rst_swap_done", swap_done, 0);
    check("rst_row_addr", row_addr, 0);
    reset = 1'b0;
    @(negedge clk);
    check("first_frame_start", frame_start, 1);
    for (int f = 0; f < 2; f++) begin
      n = 0; lit = 0;
      do begin
        @(negedge clk); n++;
        if (led_col != 8'hFF) lit++;
      end while (!frame_start && n < 5000);
      check("frame_period", n, FRAME);
      check("empty_frame_dark", lit, 0);
    end

    // Table: write one row, swap, then measure that row over the new frame.
    foreach (vecs[i]) begin
      brightness = vecs[i].bright;
      write_row(vecs[i].row, vecs[i].data);
      pulse_swap();
      wait_sd("vec_swap_done");
      check("vec_swap_with_fs", frame_start, 1);
      on = 0; lit = 0; other = 0; flit = 0;
      for (int c = 0; c < FRAME; c++) begin
        if (led_row == 8'(1 << vecs[i].row)) begin
          on++;
          if (led_col == vecs[i].exp_col) lit++;
          else if (led_col != 8'hFF) other++;
        end
        if (led_col != 8'hFF) flit++;
        if (c < FRAME - 1) @(negedge clk);
      end
      check("vec_on_ticks", on, vecs[i].exp_on);
      check("vec_lit_ticks", lit, vecs[i].exp_lit);
      check("vec_wrong_pattern", other, 0);
      if (vecs[i].chk_dark) check("vec_frame_dark", flit, 0);
    end

    // Mid-frame swap request: nothing changes on screen until the boundary.
    brightness = 8'd200;
    wait_fs("mid_fs");
    tick_n(600);
    write_row(2, 8'h11);
    write_row(5, 8'h22);
    pulse_swap();
    n = 0; other = 0; lit = 0;
    do begin
      @(negedge clk); n++;
      if (!frame_start && swap_done) other++;
      if (!frame_start && led_row == 8'h20 && led_col == 8'hDD) lit++;
    end while (!frame_start && n < 5000);
    check("mid_boundary", frame_start, 1);
    check("mid_swap_at_boundary", swap_done, 1);
    check("mid_early_swap", other, 0);
    check("mid_no_tearing", lit, 0);
    lit = 0;
    for (int c = 0; c < FRAME - 1; c++) begin
      @(negedge clk);
      if (led_row == 8'h20 && led_col == 8'hDD) lit++;
    end
    check("mid_new_row5_lit", lit, 200);

    // Swap request and write on the swap edge itself.
    brightness = 8'd255;
    wait_fs("se_fs");
    tick_n(100);
    pulse_swap();
    tick_n(FRAME - 1 - 101);
    swap_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h0F;
    @(negedge clk);
    swap_req = 1'b0; wr_en = 1'b0;
    check("se_frame_start", frame_start, 1);
    check("se_swap_done", swap_done, 1);
    lit = 0;
    for (int c = 0; c < FRAME - 1; c++) begin
      @(negedge clk);
      if (led_row == 8'h10 && led_col == 8'hF0) lit++;
    end
    check("se_write_visible", lit, 255);
    @(negedge clk);
    check("se_second_fs", frame_start, 1);
    check("se_second_swap", swap_done, 1);
    wait_fs("se_third_fs");
    check("se_no_third_swap", swap_done, 0);

    // Reset during row 5 ON.
    wait_fs("rst_mid_fs");
    tick_n(5 * ROW_T + BL + 20);
    check("rst_mid_row5", led_row, 8'h20);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_led_row", led_row, 8'h00);
    check("rst_mid_led_col", led_col, 8'hFF);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_restart_fs", frame_start, 1);
    check("rst_mid_row_addr", row_addr, 0);
    lit = 0;
    for (int c = 0; c < FRAME - 1; c++) begin
      @(negedge clk);
      if (led_col != 8'hFF) lit++;
    end
    check("rst_mid_cleared", lit, 0);
    @(negedge clk);
    check("rst_mid_period", frame_start, 1);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 12000; c++) begin
      wr_en    = ($urandom_range(7) == 0);
      wr_addr  = 3'($urandom_range(7));
      wr_data  = 8'($urandom);
      swap_req = ($urandom_range(499) == 0);
      if ($urandom_range(299) == 0) brightness = 8'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0; swap_req = 1'b0;

    // Out-of-range row addresses on the six-row instance are ignored.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    brightness = 8'd255;
    write_row(2, 8'h3C);
    write_row(6, 8'hFF);
    write_row(7, 8'hFF);
    pulse_swap();
    n = 0;
    do begin @(negedge clk); n++; end while (!swap_done6 && n < 5000);
    check("r6_swap_done", swap_done6, 1);
    check("r6_swap_with_fs", frame_start6, 1);
    lit = 0; on = 0;
    for (int c = 0; c < 6 * ROW_T; c++) begin
      if (led_col6 != 8'hFF) lit++;
      if (led_col6 == 8'hC3 && led_row6 == 6'b000100) on++;
      if (c < 6 * ROW_T - 1) @(negedge clk);
    end
    check("r6_total_lit", lit, 255);
    check("r6_row2_lit", on, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
